// File: rtl/layer_train_driver.sv
// layer_train_driver: presents one buffered sample to a learning layer, captures its response, optionally fires one learn cycle.
// Optional ERR_ACCUM_EN adds a saturating error accumulator and a result counter.
module layer_train_driver #(
  parameter int N      = 16,
  parameter int M      = 40,
  parameter int SETTLE = 2,
  parameter int ZW     = 8,
  parameter int EW     = ZW + $clog2(M)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic                 s_learn_i,
  input  logic [N-1:0][ZW-1:0] s_in_i,
  input  logic [M-1:0][ZW-1:0] s_expected_i,
  output logic                 valid_o,
  output logic                 learn_o,
  output logic [N-1:0][ZW-1:0] in_o,
  output logic [M-1:0][ZW-1:0] expected_out_o,
  input  logic [M-1:0][ZW-1:0] out_i,
  input  logic [N-1:0][ZW-1:0] expected_in_i,
`ifdef ERR_ACCUM_EN
  input  logic                 acc_clear_i,
  output logic [31:0]          acc_err_o,
  output logic [15:0]          acc_count_o,
`endif
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [M-1:0][ZW-1:0] r_out_o,
  output logic [N-1:0][ZW-1:0] r_expected_in_o,
  output logic [EW-1:0]        r_err_o,
  output logic                 r_learned_o
);
  typedef enum logic [2:0] {IDLE, PRESENT, CAPTURE, LEARN, RESULT} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lrn_q, lrn_d, rlearned_q, rlearned_d;
  logic [N-1:0][ZW-1:0]  in_q, in_d, rexp_q, rexp_d;
  logic [M-1:0][ZW-1:0]  exp_q, exp_d, rout_q, rout_d;
  logic [EW-1:0]         err_q, err_d, err_sum;
  always_comb begin
    err_sum = '0;
    for (int i = 0; i < M; i++)
      err_sum += EW'(exp_q[i] > out_i[i] ? exp_q[i] - out_i[i] : out_i[i] - exp_q[i]);
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lrn_d      = lrn_q;
    rlearned_d = rlearned_q;
    in_d       = in_q;
    exp_d      = exp_q;
    rout_d     = rout_q;
    rexp_d     = rexp_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (s_valid_i) begin
        in_d       = s_in_i;
        exp_d      = s_expected_i;
        lrn_d      = s_learn_i;
        rlearned_d = 1'b0;
        state_d    = PRESENT;
      end
      PRESENT: begin
        cnt_d   = cnt_q == 4'(SETTLE - 1) ? 4'd0 : cnt_q + 4'd1;
        state_d = cnt_q == 4'(SETTLE - 1) ? CAPTURE : PRESENT;
      end
      CAPTURE: begin
        rout_d  = out_i;
        rexp_d  = expected_in_i;
        err_d   = err_sum;
        state_d = lrn_q ? LEARN : RESULT;
      end
      LEARN: begin
        rlearned_d = 1'b1;
        state_d    = RESULT;
      end
      RESULT: state_d = r_ready_i ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lrn_q      <= 1'b0;
      rlearned_q <= 1'b0;
      in_q       <= '0;
      exp_q      <= '0;
      rout_q     <= '0;
      rexp_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lrn_q      <= lrn_d;
      rlearned_q <= rlearned_d;
      in_q       <= in_d;
      exp_q      <= exp_d;
      rout_q     <= rout_d;
      rexp_q     <= rexp_d;
      err_q      <= err_d;
    end
  end
  assign s_ready_o       = state_q == IDLE;
  assign valid_o         = state_q == PRESENT || state_q == CAPTURE || state_q == LEARN;
  assign learn_o         = state_q == LEARN;
  assign r_valid_o       = state_q == RESULT;
  assign in_o            = in_q;
  assign expected_out_o  = exp_q;
  assign r_out_o         = rout_q;
  assign r_expected_in_o = rexp_q;
  assign r_err_o         = err_q;
  assign r_learned_o     = rlearned_q;
`ifdef ERR_ACCUM_EN
  logic [31:0] acc_err_q;
  logic [15:0] acc_count_q;
  logic [32:0] acc_sum;
  assign acc_sum = {1'b0, acc_err_q} + 33'(err_q);
  // clear takes priority over a coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_err_q   <= '0;
      acc_count_q <= '0;
    end else if (acc_clear_i) begin
      acc_err_q   <= '0;
      acc_count_q <= '0;
    end else if (r_valid_o && r_ready_i) begin
      acc_err_q   <= acc_sum[32] ? '1 : acc_sum[31:0];
      acc_count_q <= acc_count_q + 16'd1;
    end
  end
  assign acc_err_o   = acc_err_q;
  assign acc_count_o = acc_count_q;
`endif
endmodule

// File: tb/tb_layer_train_driver.sv
// tb_layer_train_driver: directed checks of handshakes, latency, learn pulse, back-pressure and mid-sample reset.
module tb_layer_train_driver;
  localparam int N = 16, M = 40, ZW = 8, EW = ZW + $clog2(M);
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic s_valid, s_ready, s_learn, valid, learn, r_valid, r_ready, r_learned;
  logic [N-1:0][ZW-1:0] s_in, in_v, expected_in, r_expected_in, pa, pc;
  logic [M-1:0][ZW-1:0] s_expected, expected_out, out_v, r_out, pb, ones;
  logic [EW-1:0] r_err;
`ifdef ERR_ACCUM_EN
  logic acc_clear;
  logic [31:0] acc_err;
  logic [15:0] acc_count;
`endif
  int total = 0, bad = 0, lv = 0;
  int lat, vc, lc, k;
  logic stable;

  layer_train_driver dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_learn_i(s_learn),
    .s_in_i(s_in), .s_expected_i(s_expected),
    .valid_o(valid), .learn_o(learn), .in_o(in_v), .expected_out_o(expected_out),
    .out_i(out_v), .expected_in_i(expected_in),
`ifdef ERR_ACCUM_EN
    .acc_clear_i(acc_clear), .acc_err_o(acc_err), .acc_count_o(acc_count),
`endif
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_out_o(r_out),
    .r_expected_in_o(r_expected_in), .r_err_o(r_err), .r_learned_o(r_learned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic l, input logic [N-1:0][ZW-1:0] si, input logic [M-1:0][ZW-1:0] se,
                      output int lt, output int vcnt, output int lcnt);
    s_valid = 1'b1; s_learn = l; s_in = si; s_expected = se;
    lt = 0; vcnt = 0; lcnt = 0;
    do begin
      tick();
      s_valid = 1'b0;
      lt++;
      vcnt += int'(valid);
      lcnt += int'(learn);
      if ((learn && !valid) || (valid && (in_v !== si || expected_out !== se))) lv++;
    end while (!r_valid && lt < 20);
  endtask

  task automatic ack();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  initial begin
    s_valid = 0; s_learn = 0; s_in = '0; s_expected = '0; out_v = '0; expected_in = '0; r_ready = 0;
`ifdef ERR_ACCUM_EN
    acc_clear = 0;
`endif
    for (int i = 0; i < N; i++) begin pa[i] = 8'(i * 3 + 1); pc[i] = 8'(200 - i); end
    for (int i = 0; i < M; i++) begin pb[i] = 8'(i * 5 + 7); ones[i] = 8'd1; end
    #23 rst_n = 1'b1;
    tick();
    check("rst_s_ready", s_ready, 1);
    check("rst_valid", valid, 0);
    check("rst_learn", learn, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_in", in_v, 0);
    check("rst_exp_out", expected_out, 0);
    check("rst_r_out", r_out, 0);
    check("rst_r_err", r_err, 0);
    check("rst_r_learned", r_learned, 0);
    // inference, layer echoes the target
    out_v = pb; expected_in = pc;
    send(1'b0, pa, pb, lat, vc, lc);
    check("inf_latency", lat, 4);
    check("inf_valid_cycles", vc, 3);
    check("inf_learn_cycles", lc, 0);
    check("inf_r_err", r_err, 0);
    check("inf_r_learned", r_learned, 0);
    check("inf_r_out", r_out, pb);
    check("inf_r_exp_in", r_expected_in, pc);
    ack();
    check("inf_ack_r_valid", r_valid, 0);
    check("inf_ack_s_ready", s_ready, 1);
    // training, all outputs 0 vs targets 1
    out_v = '0;
    send(1'b1, pa, ones, lat, vc, lc);
    check("trn_latency", lat, 5);
    check("trn_valid_cycles", vc, 4);
    check("trn_learn_cycles", lc, 1);
    check("trn_r_err", r_err, 40);
    check("trn_r_learned", r_learned, 1);
    check("trn_r_out", r_out, 0);
    // back-pressure with a new sample already offered
    s_valid = 1'b1; s_learn = 1'b0; s_in = pc; s_expected = pb; stable = 1'b1;
    repeat (10) begin
      tick();
      if (!r_valid || s_ready || valid || learn || r_err !== 40 || r_learned !== 1 || r_out !== '0) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("bp_release_s_ready", s_ready, 1);
    check("bp_release_r_valid", r_valid, 0);
    tick();
    s_valid = 1'b0;
    check("bp_accept_valid", valid, 1);
    check("bp_accept_in", in_v, pc);
    check("bp_accept_r_learned", r_learned, 0);
    k = 0;
    while (!r_valid && k < 20) begin tick(); k++; end
    check("bp_second_r_valid", r_valid, 1);
    check("bp_second_r_err", r_err, 4180);
    ack();
    // reset while learn is asserted
    s_valid = 1'b1; s_learn = 1'b1; s_in = pa; s_expected = ones; k = 0;
    do begin tick(); s_valid = 1'b0; k++; end while (!learn && k < 20);
    check("rl_reached_learn", learn, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rl_learn_dropped", learn, 0);
    check("rl_valid_dropped", valid, 0);
    check("rl_s_ready", s_ready, 1);
    check("rl_in_cleared", in_v, 0);
    check("rl_r_learned", r_learned, 0);
    #10 rst_n = 1'b1;
    lc = 0; vc = 0;
    repeat (10) begin tick(); lc += int'(learn); vc += int'(valid); end
    check("rl_no_learn_after", lc, 0);
    check("rl_no_valid_after", vc, 0);
    check("protocol_violations", lv, 0);
`ifdef ERR_ACCUM_EN
    check("acc_rst_err", acc_err, 0);
    check("acc_rst_count", acc_count, 0);
    out_v = '0; out_v[0] = 8'd5;
    send(1'b0, pa, '0, lat, vc, lc); ack();
    out_v[0] = 8'd7;
    send(1'b1, pa, '0, lat, vc, lc); ack();
    out_v = '0;
    send(1'b0, pa, '0, lat, vc, lc); ack();
    check("acc_err_3", acc_err, 12);
    check("acc_count_3", acc_count, 3);
    out_v[0] = 8'd9;
    send(1'b0, pa, '0, lat, vc, lc);
    acc_clear = 1'b1;
    ack();
    acc_clear = 1'b0;
    check("acc_clear_err", acc_err, 0);
    check("acc_clear_count", acc_count, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_train_driver.md
Name: layer_train_driver

Overview:
- Sequencer that drives one learning layer (M neurons, N inputs) from a buffered sample stream.
- Accepts a sample (input vector plus target vector) on a valid/ready handshake and holds it stable on the layer's forward ports while the outputs settle.
- Captures out[] and the back-propagated expected_in[], optionally fires one learn cycle, then returns a result record (outputs, expected_in, absolute error) on a second valid/ready handshake.
- Sits between the training-data source and the layer; it is the initiator side of the layer's valid/learn/expected_out interface.

Parameters:
- N, 16, layer input count (width of in / expected_in vectors)
- M, 40, layer neuron count (width of out / expected_out vectors)
- SETTLE, 2, cycles valid is held with learn=0 before capture; legal range 1..15
- ZW, $bits(zero2one_t), element width, treated as unsigned for error arithmetic

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_valid  in  1  sample available
- s_ready  out  1  driver can accept a sample
- s_learn  in  1  sample is a training sample (1) or inference only (0)
- s_in  in  zero2one_t[N]  sample input vector
- s_expected  in  zero2one_t[M]  sample target vector
- valid  out  1  to layer: vectors on in/expected_out are valid
- learn  out  1  to layer: apply weight update this cycle
- in  out  zero2one_t[N]  to layer: registered input vector
- expected_out  out  zero2one_t[M]  to layer: registered target vector
- out  in  zero2one_t[M]  from layer: forward outputs
- expected_in  in  zero2one_t[N]  from layer: averaged back-propagated targets
- r_valid  out  1  result available
- r_ready  in  1  consumer accepts result
- r_out  out  zero2one_t[M]  captured layer outputs
- r_expected_in  out  zero2one_t[N]  captured expected_in
- r_err  out  ZW+$clog2(M)  sum over M of |s_expected[i] - out[i]|
- r_learned  out  1  a learn cycle was issued for this result

Behaviour:
- Reset (async, reset_n=0): state IDLE; s_ready=1; valid, learn, r_valid, r_learned = 0; in, expected_out, r_out, r_expected_in, r_err = 0; settle counter = 0.
- FSM IDLE -> PRESENT -> CAPTURE -> [LEARN] -> RESULT -> IDLE.
- IDLE: s_ready=1. On s_valid&&s_ready, register s_in, s_expected and s_learn, then go to PRESENT. No other state accepts a sample; s_ready=0 outside IDLE.
- PRESENT: valid=1, learn=0; counter counts 0..SETTLE-1, then go to CAPTURE. in/expected_out stay constant for the whole sample.
- CAPTURE: valid=1, learn=0. Register out into r_out and expected_in into r_expected_in. Compute r_err combinationally from the held target and out, then register it. Next state: LEARN if the latched learn flag is set, else RESULT.
- LEARN: exactly one cycle with valid=1 and learn=1; r_learned<=1; next state RESULT.
- RESULT: valid=0, learn=0; r_valid=1; r_* stable until r_valid&&r_ready, then go to IDLE with r_valid<=0.
- Latency, sample accept to r_valid: SETTLE+2 cycles for inference, SETTLE+3 for training.
- Throughput: one sample per SETTLE+3 (or +4) cycles when r_ready is held at 1.
- Error arithmetic: each |a-b| is unsigned ZW bits; the sum uses ZW+$clog2(M) bits, so it cannot overflow.
- Back-pressure: r_ready=0 holds RESULT indefinitely; the layer sees valid=0.
- Reset mid-sample: everything returns to reset values immediately. A pending learn cycle is never issued after reset deasserts.
- learn is never high unless valid is high in the same cycle.

Optional Feature:
- Macro ERR_ACCUM_EN.
- Defined: adds inputs acc_clear (1) and outputs acc_err (32 bits, saturating sum of r_err) and acc_count (16 bits, wrapping count of results).
- Both accumulators update on each r_valid&&r_ready handshake.
- acc_clear zeroes both accumulators; if acc_clear coincides with a handshake, the clear wins.
- Both accumulators reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is unchanged.

Test Plan:
- Reset then idle -> s_ready=1, valid=0, learn=0, r_valid=0, every vector 0.
- SETTLE=2, inference sample, layer model out=s_expected -> valid high 3 cycles, learn never 1, r_valid at accept+4, r_err=0, r_learned=0.
- Training sample, M=40, every out element 0 and every target element 1 (LSB) -> exactly one learn pulse one cycle after capture, r_err=40, r_learned=1, r_valid at accept+5.
- r_ready held 0 for 10 cycles -> r_* stable, s_ready=0, valid=0. Release r_ready -> a new sample is accepted in the next IDLE cycle.
- reset_n pulsed low during LEARN state -> learn drops asynchronously and no learn pulse follows reset release.
- ERR_ACCUM_EN: 3 samples with r_err 5, 7, 0 -> acc_err=12, acc_count=3. acc_clear concurrent with a 4th handshake -> acc_err=0, acc_count=0.
